// File: rtl/debounced_input_pio_pkg.sv
// Shared constants, types and helpers for the debounced input PIO.
package debounced_input_pio_pkg;

  localparam int NUM_INPUTS = 3;
  localparam int BIT_BUTTON = 0;
  localparam int BIT_SW0    = 1;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  typedef logic [NUM_INPUTS-1:0] in_vec_t;

  // Inputs that are electrically active-low; they idle at 1 and are
  // inverted so the logical view is "1 = asserted".
  localparam in_vec_t ACTIVE_LOW_MASK = 3'b001;

  // Zero-extend an input vector to a bus word.
  function automatic logic [31:0] pad_word(input in_vec_t v);
    return {{(32-NUM_INPUTS){1'b0}}, v};
  endfunction

  // Edge events: the button reports presses only, switches report any change.
  function automatic in_vec_t edge_events(input in_vec_t cur, input in_vec_t prev);
    in_vec_t ev;
    ev             = cur ^ prev;
    ev[BIT_BUTTON] = cur[BIT_BUTTON] & ~prev[BIT_BUTTON];
    return ev;
  endfunction

endpackage

// File: rtl/debounced_input_pio_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
interface debounced_input_pio_if;

  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );

endinterface

// File: rtl/debounced_input_pio_debounce_cell.sv
// One input lane: 2-flop synchronizer, stability counter and debounced flop.
module debounce_cell #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES+1),
  parameter logic RST_VAL         = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_sync,
  output logic o_deb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES-1);

  logic             r_meta;
  logic             r_sync;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous raw input into the clock domain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  // Accept the synchronized level only after it has differed for the full window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {CNT_W{1'b0}};
      r_deb <= RST_VAL;
    end else if (r_sync == r_deb) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_cnt == CNT_LAST) begin
      r_deb <= r_sync;
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_sync = r_sync;
  assign o_deb  = r_deb;

endmodule

// File: rtl/debounced_input_pio.sv
// Debounced pushbutton/switch PIO with edge capture, mask and level IRQ.
module debounced_input_pio
  import debounced_input_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES+1)
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic                       button_in,
  input  logic [1:0]                 switchs_in,
  debounced_input_pio_if.slave       avs,
  output logic                       irq
);

  in_vec_t w_raw;
  in_vec_t w_sync;
  in_vec_t w_deb;
  in_vec_t w_in;
  in_vec_t w_raw_view;
  in_vec_t w_edge_clr;
  logic    w_mask_we;
  logic [31:0] w_read_word;
  logic    w_unused_wdata;

  in_vec_t     r_in_prev;
  in_vec_t     r_mask;
  in_vec_t     r_edge;
  logic        r_irq;
  logic [31:0] r_readdata;

  assign w_raw[BIT_BUTTON]    = button_in;
  assign w_raw[BIT_SW0 +: 2]  = switchs_in;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RST_VAL         (ACTIVE_LOW_MASK[g])
    ) u_cell (
      .i_clk  (clk_clk),
      .i_rst  (reset_reset),
      .i_raw  (w_raw[g]),
      .o_sync (w_sync[g]),
      .o_deb  (w_deb[g])
    );
  end

  // Logical views: button inverted so 1 means pressed.
  assign w_in       = w_deb  ^ ACTIVE_LOW_MASK;
  assign w_raw_view = w_sync ^ ACTIVE_LOW_MASK;

  assign w_unused_wdata = &{1'b0, avs.avs_writedata[31:NUM_INPUTS]};

  // Decode bus writes into mask load and edge-clear strobes.
  always_comb begin
    w_mask_we  = 1'b0;
    w_edge_clr = '0;
    if (avs.avs_write) begin
      case (avs.avs_address)
        ADDR_MASK: w_mask_we  = 1'b1;
        ADDR_EDGE: w_edge_clr = avs.avs_writedata[NUM_INPUTS-1:0];
        default:   w_mask_we  = 1'b0;
      endcase
    end else begin
      w_mask_we  = 1'b0;
      w_edge_clr = '0;
    end
  end

  // Select the register word returned by a read (pre-write values).
  always_comb begin
    w_read_word = 32'd0;
    case (avs.avs_address)
      ADDR_DATA: w_read_word = pad_word(w_in);
      ADDR_MASK: w_read_word = pad_word(r_mask);
      ADDR_EDGE: w_read_word = pad_word(r_edge);
      ADDR_RAW:  w_read_word = pad_word(w_raw_view);
      default:   w_read_word = 32'd0;
    endcase
  end

  // Edge capture (set wins over clear), mask register and registered IRQ.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_in_prev <= '0;
      r_edge    <= '0;
      r_mask    <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_in_prev <= w_in;
      r_edge    <= (r_edge & ~w_edge_clr) | edge_events(w_in, r_in_prev);
      if (w_mask_we) begin
        r_mask <= avs.avs_writedata[NUM_INPUTS-1:0];
      end else begin
        r_mask <= r_mask;
      end
      r_irq     <= |(r_edge & r_mask);
    end
  end

  // Read data register: loads on a read strobe, otherwise holds.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_readdata <= 32'd0;
    end else if (avs.avs_read) begin
      r_readdata <= w_read_word;
    end else begin
      r_readdata <= r_readdata;
    end
  end

  assign avs.avs_readdata = r_readdata;
  assign irq              = r_irq;

endmodule
